// File: rtl/data_memory_arbiter_pkg.sv
// Shared definitions for the data memory arbiter slice.
//   - FSM state encoding (IDLE / ACCESS / DONE, 2 bits)
//   - default data and address widths
//   - requester identifiers (REQ_A = CPU, REQ_B = loader)
package data_memory_arbiter_pkg;

    localparam int unsigned DATA_W_DEF = 24;
    localparam int unsigned ADDR_W_DEF = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } state_e;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_id_e;

endpackage

// File: rtl/data_memory_arbiter_rr.sv
// Combinational two-way round-robin pick.
// Ports:
//   req_a, req_b  : requests from A and B
//   last_served   : requester that received the previous grant
//   grant_valid   : at least one request present
//   grant_id      : selected requester (only meaningful with grant_valid)
module rr_arbiter2
    import data_memory_arbiter_pkg::*;
(
    input  logic    req_a,
    input  logic    req_b,
    input  req_id_e last_served,
    output logic    grant_valid,
    output req_id_e grant_id
);

    always_comb begin
        grant_valid = req_a | req_b;
        grant_id    = REQ_A;
        if (req_a && req_b) begin
            // Tie: the side that did not win last time goes now.
            grant_id = (last_served == REQ_A) ? REQ_B : REQ_A;
        end else if (req_b) begin
            grant_id = REQ_B;
        end
    end

endmodule

// File: rtl/data_memory_arbiter.sv
// Arbitrates two requesters (A = CPU, B = loader) onto a single DataMemory
// port. One access per transaction: IDLE (grant) -> ACCESS (strobe) -> DONE.
// Ports:
//   Clock, Reset_n               : clock, async active-low reset
//   ReqA/B, WrA/B                : request and direction (1 = write)
//   AdresaA/B, WriteDataA/B      : access address and write data
//   GntA/B                       : request captured (1-cycle pulse)
//   DoneA/B                      : access complete (1-cycle pulse)
//   ReadDataA/B                  : registered read result per requester
//   MemAdresa, MemWriteData      : to DataMemory (latched request values)
//   MemWrite, MemRead            : to DataMemory strobes (ACCESS only)
//   MemReadData                  : from DataMemory, combinational read
module data_memory_arbiter
    import data_memory_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              ReqA,
    input  logic              ReqB,
    input  logic              WrA,
    input  logic              WrB,
    input  logic [ADDR_W-1:0] AdresaA,
    input  logic [ADDR_W-1:0] AdresaB,
    input  logic [DATA_W-1:0] WriteDataA,
    input  logic [DATA_W-1:0] WriteDataB,
    output logic              GntA,
    output logic              GntB,
    output logic              DoneA,
    output logic              DoneB,
    output logic [DATA_W-1:0] ReadDataA,
    output logic [DATA_W-1:0] ReadDataB,
    output logic [ADDR_W-1:0] MemAdresa,
    output logic [DATA_W-1:0] MemWriteData,
    output logic              MemWrite,
    output logic              MemRead,
    input  logic [DATA_W-1:0] MemReadData
);

    state_e            state_q,   state_d;
    req_id_e           last_q,    last_d;
    req_id_e           winner_q,  winner_d;
    logic              wr_q,      wr_d;
    logic [ADDR_W-1:0] addr_q,    addr_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [DATA_W-1:0] rdata_a_q, rdata_a_d;
    logic [DATA_W-1:0] rdata_b_q, rdata_b_d;

    logic    pick_valid;
    req_id_e pick_id;

    rr_arbiter2 u_rr (
        .req_a       (ReqA),
        .req_b       (ReqB),
        .last_served (last_q),
        .grant_valid (pick_valid),
        .grant_id    (pick_id)
    );

    always_comb begin
        state_d   = state_q;
        last_d    = last_q;
        winner_d  = winner_q;
        wr_d      = wr_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_a_d = rdata_a_q;
        rdata_b_d = rdata_b_q;
        GntA      = 1'b0;
        GntB      = 1'b0;
        DoneA     = 1'b0;
        DoneB     = 1'b0;
        MemWrite  = 1'b0;
        MemRead   = 1'b0;

        case (state_q)
            IDLE: begin
                // Gnt is combinational from the request, so it is gated by
                // Reset_n to stay low while reset is held.
                if (pick_valid && Reset_n) begin
                    state_d  = ACCESS;
                    last_d   = pick_id;
                    winner_d = pick_id;
                    if (pick_id == REQ_A) begin
                        GntA    = 1'b1;
                        wr_d    = WrA;
                        addr_d  = AdresaA;
                        wdata_d = WriteDataA;
                    end else begin
                        GntB    = 1'b1;
                        wr_d    = WrB;
                        addr_d  = AdresaB;
                        wdata_d = WriteDataB;
                    end
                end
            end
            ACCESS: begin
                MemWrite = wr_q;
                MemRead  = ~wr_q;
                state_d  = DONE;
                if (!wr_q) begin
                    if (winner_q == REQ_A) begin
                        rdata_a_d = MemReadData;
                    end else begin
                        rdata_b_d = MemReadData;
                    end
                end
            end
            DONE: begin
                DoneA   = (winner_q == REQ_A);
                DoneB   = (winner_q == REQ_B);
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q   <= IDLE;
            last_q    <= REQ_B;
            winner_q  <= REQ_A;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rdata_a_q <= '0;
            rdata_b_q <= '0;
        end else begin
            state_q   <= state_d;
            last_q    <= last_d;
            winner_q  <= winner_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata_a_q <= rdata_a_d;
            rdata_b_q <= rdata_b_d;
        end
    end

    assign MemAdresa    = addr_q;
    assign MemWriteData = wdata_q;
    assign ReadDataA    = rdata_a_q;
    assign ReadDataB    = rdata_b_q;

endmodule
